nibble_alu_sequencer: RTL
=========================

NIBBLE_ALU_SEQUENCER -- requirements
Module: nibble_alu_sequencer

Interface
REQ-001 The block SHALL have one parameter: NIBBLES, default 2, number of 4-bit passes; operand and result width W = 4*NIBBLES; legal range 1..8.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 CLR  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  request a new operation; sampled on the rising edge.
REQ-005 SU  input  1  operation select: 0 = add (A+B), 1 = subtract (A-B); sampled with START.
REQ-006 A  input  W  first operand; sampled with START.
REQ-007 B  input  W  second operand; sampled with START.
REQ-008 BUSY  output  1  high while a computation is in progress.
REQ-009 DONE  output  1  one-cycle pulse marking a valid new result.
REQ-010 S  output  W  registered result; holds its value between completions.
REQ-011 CF  output  1  registered carry-out of the most significant nibble.
REQ-012 ZF  output  1  registered zero flag, high when S equals 0.

Function
REQ-013 The datapath SHALL contain exactly one 4-bit adder with carry-in and carry-out, time-shared over NIBBLES cycles, least significant nibble first.
REQ-014 The FSM SHALL have three states: IDLE, RUN, FIN.
REQ-015 IDLE: BUSY=0, DONE=0; on START=1, latch A, latch B (bitwise inverted when SU=1), load the carry flip-flop with SU, clear the nibble index, go to RUN.
REQ-016 RUN: BUSY=1; each cycle, add nibble[index] of latched A, latched B and the carry flip-flop; store the 4-bit sum into result nibble[index]; load carry-out into the carry flip-flop; increment the index.
REQ-017 RUN SHALL go to FIN in the cycle after it processes nibble NIBBLES-1; otherwise it SHALL stay in RUN.
REQ-018 FIN: DONE=1, BUSY=0; S, CF and ZF SHALL show the new result in this same cycle; S, CF and ZF SHALL be loaded together on the edge that enters FIN.
REQ-019 FIN: on START=1, latch new operands as in REQ-015 and go to RUN, so back-to-back operations have no idle gap; otherwise go to IDLE.
REQ-020 Latency: with START high at edge 0, DONE SHALL be high during cycle NIBBLES+1, which is cycle 3 for the default.
REQ-021 START SHALL be ignored while in RUN; the latched operands and SU SHALL NOT change during RUN.
REQ-022 Arithmetic is modulo 2^W. For add, CF = unsigned overflow. For subtract, CF=1 means no borrow (A >= B unsigned) and CF=0 means a borrow occurred.
REQ-023 ZF SHALL be computed from the full W-bit final result, never from a single nibble.
REQ-024 S, CF and ZF SHALL NOT change during RUN; partial sums SHALL remain internal.
REQ-025 Changes to A, B or SU outside the START sampling edge SHALL have no effect.

Reset
REQ-026 CLR=1 at a rising edge SHALL force IDLE and set BUSY=0, DONE=0, S=0, CF=0, ZF=0, carry flip-flop = 0 and index = 0.
REQ-027 CLR SHALL take priority over START in every state.
REQ-028 CLR during RUN SHALL abort the operation; no DONE SHALL follow for the aborted operation.

Verification
REQ-029 Add, NIBBLES=2: START, SU=0, A=0x3C, B=0x15 at edge 0 -> BUSY high in cycles 1-2; DONE high in cycle 3 only; S=0x51, CF=0, ZF=0.
REQ-030 Add wrap-around: A=0xFF, B=0x01, SU=0 -> S=0x00, CF=1, ZF=1; the carry passes from the low nibble into the high nibble.
REQ-031 Subtract: A=0x20, B=0x21, SU=1 -> S=0xFF, CF=0. A=0x21, B=0x21, SU=1 -> S=0x00, CF=1, ZF=1.
REQ-032 START pulsed during RUN with A=0x01, B=0x01 -> ignored; the result of the original operation appears, followed by exactly one DONE.
REQ-033 CLR asserted in cycle 2 of an operation -> IDLE next cycle, all outputs 0, no DONE; a fresh operation then completes normally.
REQ-034 START held high through FIN with new operands -> the second operation starts immediately; second DONE arrives exactly NIBBLES+1 cycles after the first.

Source files
------------

// File: rtl/nibble_alu_sequencer.sv
// ============================================================================
// Module      : nibble_alu_sequencer
// Description : W-bit add/subtract unit built around a single 4-bit adder.
//               The adder is reused once per nibble, least significant nibble
//               first. S, CF and ZF change only when a result completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_alu_sequencer #(
  parameter int NIBBLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_clr,
  input  logic                   i_start,
  input  logic                   i_su,
  input  logic [4*NIBBLES-1:0]   i_a,
  input  logic [4*NIBBLES-1:0]   i_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*NIBBLES-1:0]   o_s,
  output logic                   o_cf,
  output logic                   o_zf
);

  localparam int c_W    = 4 * NIBBLES;
  localparam int c_IDXW = $clog2(NIBBLES + 1);
  localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(NIBBLES - 1);
  localparam logic [c_IDXW-1:0] c_ONE  = c_IDXW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;
  logic              w_last;

  logic [c_W-1:0]    r_a;
  logic [c_W-1:0]    r_b;
  logic              r_cy;
  logic [c_IDXW-1:0] r_idx;
  logic [c_W-1:0]    r_part;

  logic [3:0]        w_na;
  logic [3:0]        w_nb;
  logic [4:0]        w_sum;
  logic [c_W-1:0]    w_final;

  // State register; clear always wins.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (r_idx == c_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        o_done = 1'b1;
        // Accepting here gives back-to-back operations with no idle cycle.
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    w_na = 4'h0;
    w_nb = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == c_IDXW'(i)) begin
        w_na = r_a[i*4 +: 4];
        w_nb = r_b[i*4 +: 4];
      end
    end
  end

  // The one shared 4-bit adder with carry-in and carry-out.
  assign w_sum = {1'b0, w_na} + {1'b0, w_nb} + {4'b0000, r_cy};

  // Full result as it will look once the current nibble is written back.
  always_comb begin
    w_final = r_part;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == c_IDXW'(i)) begin
        w_final[i*4 +: 4] = w_sum[3:0];
      end
    end
  end

  // Operand latches, carry flip-flop, nibble index and partial result.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cy   <= 1'b0;
      r_idx  <= '0;
      r_part <= '0;
    end else if (w_load) begin
      // Subtract is A + ~B + 1: invert B here and seed the carry with SU.
      r_a   <= i_a;
      r_b   <= i_su ? ~i_b : i_b;
      r_cy  <= i_su;
      r_idx <= '0;
    end else if (o_busy) begin
      r_cy  <= w_sum[4];
      r_idx <= r_idx + c_ONE;
      for (int i = 0; i < NIBBLES; i++) begin
        if (r_idx == c_IDXW'(i)) begin
          r_part[i*4 +: 4] <= w_sum[3:0];
        end
      end
    end
  end

  // Visible result and flags, all loaded together on the edge entering FIN.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      o_s  <= '0;
      o_cf <= 1'b0;
      o_zf <= 1'b0;
    end else if (w_last) begin
      o_s  <= w_final;
      o_cf <= w_sum[4];
      o_zf <= (w_final == '0);
    end
  end

endmodule

`default_nettype wire
